// File: rtl/decode_stage.sv
// decode_stage: handshaked decode register with an optional skid entry.
// Holds one instruction (plus an optional second one in the skid entry),
// slices the fixed fields and classifies the instruction format.
module decode_stage #(
  parameter int          PC_W     = 32,
  parameter logic [31:0] NOP_INSN = 32'h0000_0000,
  parameter int          SKID_EN  = 1,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      insn_in,
  input  logic [PC_W-1:0]  pc_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      insn_out,
  output logic [PC_W-1:0]  pc_out,
  output logic [5:0]       opcode,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       sha,
  output logic [5:0]       func,
  output logic [15:0]      immed,
  output logic [25:0]      target,
  output logic [31:0]      imm_sext,
  output logic [1:0]       fmt,
  output logic             illegal,
  output logic [CNT_W-1:0] stat_insn_cnt
);

  localparam logic [1:0] FMT_R   = 2'd0;
  localparam logic [1:0] FMT_I   = 2'd1;
  localparam logic [1:0] FMT_J   = 2'd2;
  localparam logic [1:0] FMT_ILL = 2'd3;

  // Instruction-format class from the opcode's two octal digits.
  function automatic logic [1:0] decode_fmt(input logic [5:0] op);
    logic [1:0] f;
    f = FMT_ILL;
    case (op[5:3])
      3'd0: begin
        case (op[2:0])
          3'd0:       f = FMT_R;
          3'd2, 3'd3: f = FMT_J;
          default:    f = FMT_I;
        endcase
      end
      3'd1, 3'd4, 3'd5: f = FMT_I;
      3'd3:             f = FMT_R;
      default:          f = FMT_ILL;
    endcase
    return f;
  endfunction

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Skid entry (p0) feeds the output entry (p1).
  logic              skid_vld_p0;
  logic [31:0]       skid_insn_p0;
  logic [PC_W-1:0]   skid_pc_p0;
  logic              vld_p1;
  logic [31:0]       insn_p1;
  logic [PC_W-1:0]   pc_p1;
  logic [CNT_W-1:0]  cnt_p1;

  logic acc_xfer;
  logic out_xfer;
  logic out_free;
  logic vld_p1_nxt;
  logic skid_vld_nxt;
  logic out_ld_in;
  logic out_ld_skid;
  logic skid_ld;

  // With the skid entry, in_ready comes straight from a flop; without it,
  // in_ready looks through to out_ready.
  assign in_ready = (SKID_EN != 0) ? ~skid_vld_p0 : (~vld_p1 | out_ready);
  assign acc_xfer = in_valid & in_ready;
  assign out_xfer = vld_p1 & out_ready;
  assign out_free = ~vld_p1 | out_xfer;

  // Next-state of both entries; flush wins, then skid drain, then accept.
  // A full skid entry implies in_ready=0, so drain and accept never collide.
  always_comb begin
    vld_p1_nxt   = vld_p1;
    skid_vld_nxt = skid_vld_p0;
    out_ld_in    = 1'b0;
    out_ld_skid  = 1'b0;
    skid_ld      = 1'b0;
    if (flush) begin
      vld_p1_nxt   = 1'b0;
      skid_vld_nxt = 1'b0;
    end else if (skid_vld_p0 && out_xfer) begin
      out_ld_skid  = 1'b1;
      vld_p1_nxt   = 1'b1;
      skid_vld_nxt = 1'b0;
    end else if (acc_xfer && out_free) begin
      out_ld_in    = 1'b1;
      vld_p1_nxt   = 1'b1;
    end else if (acc_xfer) begin
      skid_ld      = 1'b1;
      skid_vld_nxt = 1'b1;
    end else if (out_xfer) begin
      vld_p1_nxt   = 1'b0;
    end
  end

  // ---- stage p0/p1 control: valids, held PC and transfer counter ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_vld_p0 <= 1'b0;
      vld_p1      <= 1'b0;
      pc_p1       <= '0;
      cnt_p1      <= '0;
    end else begin
      skid_vld_p0 <= skid_vld_nxt;
      vld_p1      <= vld_p1_nxt;
      if (out_ld_skid)
        pc_p1 <= skid_pc_p0;
      else if (out_ld_in)
        pc_p1 <= pc_in;
      if (out_xfer)
        cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  // Data payload registers; their contents only matter while the valid is set.
  always_ff @(posedge clk) begin
    if (skid_ld) begin
      skid_insn_p0 <= insn_in;
      skid_pc_p0   <= pc_in;
    end
    if (out_ld_skid)
      insn_p1 <= skid_insn_p0;
    else if (out_ld_in)
      insn_p1 <= insn_in;
  end

  // ---- output decode from the p1 registers ----
  assign out_valid     = vld_p1;
  assign insn_out      = vld_p1 ? insn_p1 : NOP_INSN;
  assign pc_out        = pc_p1;
  assign opcode        = insn_out[31:26];
  assign rs            = insn_out[25:21];
  assign rt            = insn_out[20:16];
  assign rd            = insn_out[15:11];
  assign sha           = insn_out[10:6];
  assign func          = insn_out[5:0];
  assign immed         = insn_out[15:0];
  assign target        = insn_out[25:0];
  assign imm_sext      = {{16{immed[15]}}, immed};
  assign fmt           = decode_fmt(opcode);
  assign illegal       = vld_p1 && (fmt == FMT_ILL);
  assign stat_insn_cnt = cnt_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed vectors are pushed on accept,
// a monitor pops and compares on every output transfer.
module tb_decode_stage;

  typedef struct {
    logic [31:0] insn;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sha;
    logic [5:0]  fn;
    logic [31:0] sx;
    logic [25:0] tg;
    logic [1:0]  f;
    logic        il;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [31:0] pc;
  } exp_t;

  localparam logic [31:0] NOP1 = 32'hFC00_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [31:0] insn_in = '0, pc_in = '0;
  logic out_valid, out_ready = 1'b0;
  logic [31:0] insn_out, pc_out, imm_sext, stat_insn_cnt;
  logic [5:0] opcode, func;
  logic [4:0] rs, rt, rd, sha;
  logic [15:0] immed;
  logic [25:0] target;
  logic [1:0] fmt;
  logic illegal;

  logic in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b0;
  logic [31:0] insn_in2 = '0, insn_out2, imm_sext2;
  logic [15:0] pc_in2 = '0, pc_out2, immed2;
  logic [5:0] opcode2, func2;
  logic [4:0] rs2, rt2, rd2, sha2;
  logic [25:0] target2;
  logic [1:0] fmt2, cnt2;
  logic illegal2;

  int pass_cnt = 0;
  int total_cnt = 0;
  exp_t q[$];
  vec_t vt[8];

  always #5 clk = ~clk;

  decode_stage #(.PC_W(32), .NOP_INSN(NOP1), .SKID_EN(1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .insn_in(insn_in), .pc_in(pc_in), .out_valid(out_valid), .out_ready(out_ready),
    .insn_out(insn_out), .pc_out(pc_out), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .sha(sha), .func(func), .immed(immed), .target(target), .imm_sext(imm_sext),
    .fmt(fmt), .illegal(illegal), .stat_insn_cnt(stat_insn_cnt));

  decode_stage #(.PC_W(16), .SKID_EN(0), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(in_valid2), .in_ready(in_ready2),
    .insn_in(insn_in2), .pc_in(pc_in2), .out_valid(out_valid2), .out_ready(out_ready2),
    .insn_out(insn_out2), .pc_out(pc_out2), .opcode(opcode2), .rs(rs2), .rt(rt2), .rd(rd2),
    .sha(sha2), .func(func2), .immed(immed2), .target(target2), .imm_sext(imm_sext2),
    .fmt(fmt2), .illegal(illegal2), .stat_insn_cnt(cnt2));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic vec_t mk(input logic [31:0] i, input logic [5:0] op,
                              input logic [4:0] rs_e, input logic [4:0] rt_e,
                              input logic [4:0] rd_e, input logic [4:0] sh_e,
                              input logic [5:0] fn_e, input logic [31:0] sx_e,
                              input logic [25:0] tg_e, input logic [1:0] f_e,
                              input logic il_e);
    vec_t v;
    v.insn = i; v.op = op; v.rs = rs_e; v.rt = rt_e; v.rd = rd_e; v.sha = sh_e;
    v.fn = fn_e; v.sx = sx_e; v.tg = tg_e; v.f = f_e; v.il = il_e;
    return v;
  endfunction

  // Monitor: every output transfer of the main DUT must match the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_output", {32'h0, pc_out}, 64'hDEAD);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("insn_out", {32'h0, insn_out}, {32'h0, e.v.insn});
        chk("pc_out", {32'h0, pc_out}, {32'h0, e.pc});
        chk("fields", {opcode, rs, rt, rd, sha, func}, {e.v.op, e.v.rs, e.v.rt, e.v.rd, e.v.sha, e.v.fn});
        chk("imm_sext", {32'h0, imm_sext}, {32'h0, e.v.sx});
        chk("target", {38'h0, target}, {38'h0, e.v.tg});
        chk("fmt_illegal", {fmt, illegal}, {e.v.f, e.v.il});
      end
    end
  end

  task automatic send(input vec_t v, input logic [31:0] pc, output int tries);
    logic acc;
    acc = 1'b0;
    tries = 0;
    in_valid = 1'b1; insn_in = v.insn; pc_in = pc;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tries++;
      acc = in_ready;
      if (acc && !flush) begin
        exp_t e;
        e.v = v; e.pc = pc;
        q.push_back(e);
      end
      @(posedge clk); #1;
      if (acc) break;
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain_empty", q.size(), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    vt[0] = mk(32'h012A4020, 6'h00, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 32'h0000_4020, 26'h12A_4020, 2'd0, 1'b0);
    vt[1] = mk(32'h2128FFFC, 6'h08, 5'd9, 5'd8, 5'd31, 5'd31, 6'h3C, 32'hFFFF_FFFC, 26'h128_FFFC, 2'd1, 1'b0);
    vt[2] = mk(32'h8D090004, 6'h23, 5'd8, 5'd9, 5'd0, 5'd0, 6'h04, 32'h0000_0004, 26'h109_0004, 2'd1, 1'b0);
    vt[3] = mk(32'h08100000, 6'h02, 5'd0, 5'd16, 5'd0, 5'd0, 6'h00, 32'h0, 26'h010_0000, 2'd2, 1'b0);
    vt[4] = mk(32'hFC000000, 6'h3F, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 32'h0, 26'h0, 2'd3, 1'b1);
    vt[5] = mk(32'h40000000, 6'h10, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 32'h0, 26'h0, 2'd3, 1'b1);
    vt[6] = mk(32'h70000000, 6'h1C, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 32'h0, 26'h0, 2'd0, 1'b0);
    vt[7] = mk(32'h04000000, 6'h01, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 32'h0, 26'h0, 2'd1, 1'b0);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_insn_out", insn_out, NOP1);
    chk("rst_pc_out", pc_out, 0);
    chk("rst_fmt", fmt, 3);
    chk("rst_illegal", illegal, 0);
    chk("rst_cnt", stat_insn_cnt, 0);
    rst = 1'b0;

    // Full-rate stream of all vectors
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(vt[i], 32'h0040_0000 + 32'(4 * i), t);
      chk("stream_accept_tries", t, 1);
    end
    drain();
    @(negedge clk);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_illegal", illegal, 0);
    chk("idle_insn_nop", insn_out, NOP1);
    chk("cnt_after_stream", stat_insn_cnt, 8);
    @(posedge clk); #1;

    // Backpressure through the skid entry
    out_ready = 1'b0;
    send(vt[0], 32'd0, t);
    chk("bp_first_tries", t, 1);
    send(vt[1], 32'd4, t);
    chk("bp_second_tries", t, 1);
    in_valid = 1'b1; insn_in = vt[2].insn; pc_in = 32'd8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_hold_pc", pc_out, 0);
      chk("bp_hold_insn", insn_out, vt[0].insn);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_still_low", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_ready_back", in_ready, 1);
    @(posedge clk); #1;
    send(vt[2], 32'd8, t);
    send(vt[3], 32'd12, t);
    drain();
    @(negedge clk);
    chk("cnt_after_bp", stat_insn_cnt, 12);
    @(posedge clk); #1;

    // Flush with both entries full; the head transfers in the flush cycle
    out_ready = 1'b0;
    send(vt[4], 32'h100, t);
    send(vt[5], 32'h104, t);
    flush = 1'b1; in_valid = 1'b1; insn_in = vt[6].insn; pc_in = 32'h108; out_ready = 1'b1;
    void'(q.pop_back());
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_insn_nop", insn_out, NOP1);
    chk("flush_in_ready", in_ready, 1);
    @(posedge clk); #1;
    // Flush with an accept in the same cycle: the word must vanish
    flush = 1'b1; in_valid = 1'b1; insn_in = vt[7].insn; pc_in = 32'h10C;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_acc_dropped", out_valid, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("cnt_after_flush", stat_insn_cnt, 13);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    send(vt[0], 32'h200, t);
    send(vt[1], 32'h204, t);
    #2;
    rst = 1'b1;
    q.delete();
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_insn_out", insn_out, NOP1);
    chk("arst_pc_out", pc_out, 0);
    chk("arst_illegal", illegal, 0);
    chk("arst_cnt", stat_insn_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("arst_after_valid", out_valid, 0);
    @(posedge clk); #1;

    // Saturating counter and throughput on the 2-bit, no-skid instance
    in_valid2 = 1'b1; out_ready2 = 1'b1; insn_in2 = vt[0].insn;
    for (int i = 0; i < 5; i++) begin
      pc_in2 = 16'(4 * i);
      @(posedge clk); #1;
      chk("noskid_out_valid", out_valid2, 1);
    end
    in_valid2 = 1'b0;
    @(posedge clk); #1;
    chk("sat_cnt", cnt2, 3);
    in_valid2 = 1'b1; out_ready2 = 1'b0;
    @(posedge clk); #1;
    chk("noskid_ready_low", in_ready2, 0);
    out_ready2 = 1'b1;
    #1;
    chk("noskid_ready_comb", in_ready2, 1);
    in_valid2 = 1'b0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, handshaked decode pipeline stage sitting between fetch and the control/execute stages. Accepts one instruction word plus its PC per cycle over a valid/ready interface, registers it, and presents the sliced fields (opcode, rs, rt, rd, sha, func, immed, target), a sign-extended immediate, an instruction-format class and an illegal-opcode flag. An optional one-entry skid buffer keeps `in_ready` fully registered. A synchronous flush turns all held instructions into bubbles, and a saturating counter tracks decoded instructions.

## Interface

**Parameters**
- `PC_W`, default 32: width of `pc_in` / `pc_out`.
- `NOP_INSN`, default 32'h0000_0000: word driven on `insn_out` when no valid instruction is held.
- `SKID_EN`, default 1: 1 adds a skid entry and registers `in_ready`; 0 gives a single register with combinational `in_ready`.
- `CNT_W`, default 32: width of `stat_insn_cnt`.

**Ports**
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `flush` in 1: synchronous kill of all held instructions.
- `in_valid` in 1: upstream offers `insn_in` / `pc_in`.
- `in_ready` out 1: stage can accept this cycle.
- `insn_in` in 32: instruction word.
- `pc_in` in PC_W: PC of `insn_in`.
- `out_valid` out 1: output fields describe a live instruction.
- `out_ready` in 1: downstream consumes this cycle.
- `insn_out` out 32: held instruction, or `NOP_INSN` when `out_valid`=0.
- `pc_out` out PC_W: PC of the held instruction.
- `opcode` out 6: `insn_out[31:26]`.
- `rs` out 5: `insn_out[25:21]`.
- `rt` out 5: `insn_out[20:16]`.
- `rd` out 5: `insn_out[15:11]`.
- `sha` out 5: `insn_out[10:6]`.
- `func` out 6: `insn_out[5:0]`.
- `immed` out 16: `insn_out[15:0]`.
- `target` out 26: `insn_out[25:0]`.
- `imm_sext` out 32: `{{16{immed[15]}}, immed}`.
- `fmt` out 2: 0 = R, 1 = I, 2 = J, 3 = illegal.
- `illegal` out 1: `out_valid` && `fmt`==3.
- `stat_insn_cnt` out CNT_W: count of output transfers, saturating.

## Operation

- Accept transfer = `in_valid` && `in_ready`; output transfer = `out_valid` && `out_ready`.
- Registers: output entry (valid, insn, pc); when SKID_EN=1, also a skid entry (valid, insn, pc).
- Field outputs are sliced combinationally from the output-entry registers. All outputs depend only on registers; no input-to-output combinational path except `in_ready` when SKID_EN=0.
- Format classes, by `opcode[5:3]` / `opcode[2:0]`:
  - `opcode[5:3]`=0: `opcode[2:0]`=0 gives R; 2 or 3 gives J; any other value gives I.
  - `opcode[5:3]`=1, 4 or 5 gives I.
  - `opcode[5:3]`=3 gives R.
  - `opcode[5:3]`=2, 6 or 7 gives illegal.
- When `out_valid`=0, `insn_out` is forced to `NOP_INSN`, so all fields decode from `NOP_INSN`, and `illegal`=0.
- SKID_EN=1:
  - `in_ready` = !skid_valid, taken from a register.
  - On accept: if the output entry is empty or is being consumed this cycle, the word goes to the output entry; otherwise it goes to the skid entry.
  - On an output transfer with the skid entry full, the skid entry moves to the output entry and the skid entry becomes empty.
  - Ordering is strictly FIFO.
- SKID_EN=0: `in_ready` = !out_valid || out_ready.
- Flush:
  - Has priority over everything else: clears output and skid valid at the next edge.
  - An accept in the flush cycle is discarded.
  - An output transfer in the flush cycle still counts.
- `stat_insn_cnt` increments on each output transfer and saturates at all-ones.

## Timing

- Reset values: `out_valid`=0, skid valid=0, `in_ready`=1, `insn_out`=`NOP_INSN`, `pc_out`=0, `fmt`=decode of `NOP_INSN`, `illegal`=0, `stat_insn_cnt`=0.
- Latency: an instruction accepted at edge N shows `out_valid`=1 with decoded fields after edge N.
- Throughput is 1 instruction/cycle with `out_ready` held high, for both SKID_EN values.
- SKID_EN=1 backpressure: with `out_ready`=0 and the output entry full, one more word is accepted into the skid entry, then `in_ready` drops on the following cycle. After `out_ready` returns, `in_ready` rises one cycle later.
- Outputs hold stable while `out_valid`=1 and `out_ready`=0.
- Asserting `rst` mid-transfer clears both entries immediately. No transfer completes in that cycle.

## Test plan

- **R-type:** accept `insn_in`=32'h012A4020, `pc_in`=32'h0040_0000 → next cycle `out_valid`=1, `opcode`=0, `rs`=9, `rt`=10, `rd`=8, `sha`=0, `func`=6'h20, `fmt`=0, `pc_out`=32'h0040_0000.
- **I-type and J-type:**
  - 32'h2128FFFC → `fmt`=1, `rs`=9, `rt`=8, `imm_sext`=32'hFFFF_FFFC.
  - 32'h8D090004 → `fmt`=1, `imm_sext`=4.
  - 32'h08100000 → `fmt`=2, `target`=26'h010_0000.
- **Illegal:** 32'hFC000000 (opcode 6'h3F) → `fmt`=3, `illegal`=1. When not valid, `illegal`=0.
- **Backpressure (SKID_EN=1):** stream PCs 0,4,8,12 with `out_ready`=0 → PCs 0 and 4 held, `in_ready`=0 from the third cycle on. Release `out_ready` → outputs 0,4,8,12 in order, no loss or duplication, `stat_insn_cnt`=4.
- **Flush:** flush while both entries are full and `in_valid`=1 → next cycle `out_valid`=0, `insn_out`=`NOP_INSN`, `in_ready`=1. The word offered in the flush cycle never appears.
- **Reset and saturation:**
  - Assert `rst` asynchronously mid-stream → all reset values appear immediately.
  - With CNT_W=2, five transfers → `stat_insn_cnt`=3.
